// File: rtl/factorizer_arbiter.sv
// Round-robin arbiter sharing one factorizer between two requesters: latches the
// winner's number, waits a fixed settle time, captures the factor mask, pulses done.
module factorizer_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [7:0] num0_i,
    input  logic [7:0] num1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic [7:0] result_o,
    output logic       busy_o,
    output logic [7:0] fz_number_o,
    input  logic [7:0] fz_factors_i
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [7:0]       result_q, result_d;
    logic [7:0]       fz_number_q, fz_number_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;
    logic             win;

    // Winner index: 1 selects port 1. On a tie the port that did not go last wins.
    always_comb begin
        win = 1'b0;
        unique case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last_q;
            default: win = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        result_d    = result_q;
        fz_number_d = fz_number_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        done_o      = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (|req_i) begin
                    state_d     = StWait;
                    gnt_d       = win ? 2'b10 : 2'b01;
                    fz_number_d = win ? num1_i : num0_i;
                    cnt_d       = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CntLast) begin
                    result_d = fz_factors_i;
                    state_d  = StDone;
                end
            end
            StDone: begin
                done_o  = gnt_q;
                last_d  = gnt_q[1];
                gnt_d   = 2'b00;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            gnt_q       <= 2'b00;
            result_q    <= 8'h00;
            fz_number_q <= 8'h00;
            cnt_q       <= '0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            result_q    <= result_d;
            fz_number_q <= fz_number_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign result_o    = result_q;
    assign fz_number_o = fz_number_q;
    assign busy_o      = (state_q != StIdle);

endmodule
